seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the PC width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum number of cycles mem_req may wait for mem_ack, range 1..255.
REQ-004 Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins or resumes execution from IDLE.
- icode  in  4  instruction code from fetch, sampled in FETCH.
- instr_valid  in  1  fetch decoded a legal instruction.
- imem_err  in  1  fetch address out of range.
- dmem_err  in  1  data access error, qualified by mem_ack.
- mem_ack  in  1  data memory completion.
- new_pc  in  ADDR_W  next PC from the PC-update logic.
- pc  out  ADDR_W  current PC register.
- stage  out  3  FSM state encoding.
- mem_req  out  1  data memory request.
- wb_en  out  1  register-file write strobe.
- stat  out  3  status code: AOK=1, HLT=2, ADR=3, INS=4.
- halted  out  1  high in HALT.
- instr_cnt  out  32  count of retired instructions.

Function
REQ-005 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7, and stage SHALL equal the current state.
REQ-006 IDLE SHALL go to FETCH when start=1 and hold otherwise.
REQ-007 FETCH SHALL latch icode and then go to the first matching case, in priority order:
- imem_err=1: stat=ADR, go to HALT.
- instr_valid=0: stat=INS, go to HALT.
- icode=0: stat=HLT, go to HALT.
- otherwise: go to DECODE.
REQ-008 DECODE->EXECUTE->MEMORY SHALL each take exactly one cycle.
REQ-009 In MEMORY, for latched icode in {4,5,8,9,A,B}, mem_req SHALL be high from MEMORY entry up to and including the cycle mem_ack=1, and SHALL drop on the next edge.
REQ-010 mem_ack=1 with dmem_err=0 SHALL go to WRITEBACK; mem_ack=1 with dmem_err=1 SHALL set stat=ADR and go to HALT.
REQ-011 The wait counter SHALL clear on MEMORY entry. If MEM_TIMEOUT cycles elapse without mem_ack, the block SHALL set stat=ADR, go to HALT and drop mem_req.
REQ-012 For any other icode, MEMORY SHALL last one cycle with mem_req=0, then go to WRITEBACK.
REQ-013 mem_ack SHALL be ignored outside a pending request.
REQ-014 wb_en SHALL be high for exactly the one WRITEBACK cycle; WRITEBACK then goes to PCUPD.
REQ-015 PCUPD SHALL last one cycle. On its exit edge, pc <= new_pc and instr_cnt increments, saturating at 32'hFFFF_FFFF.
REQ-016 HALT SHALL be absorbing: start is ignored; pc, stat and instr_cnt hold; mem_req=0, wb_en=0, halted=1.
REQ-017 stat SHALL be AOK in every non-HALT state.
REQ-018 pc arithmetic SHALL be ADDR_W wide; new_pc is loaded unmodified, and wrap-around is the caller's concern.

Reset
REQ-019 While rst_n=0, the block SHALL immediately set:
- state=IDLE, pc=RESET_PC, stat=AOK, instr_cnt=0
- mem_req=0, wb_en=0, halted=0
- wait counter=0, latched icode=0.
REQ-020 Reset asserted mid-instruction, including during a pending mem_req, SHALL abandon the instruction without retiring it or updating pc.

Configuration
REQ-021 With SINGLE_STEP_EN defined, PCUPD SHALL go to IDLE, so each start pulse executes exactly one instruction.
REQ-022 Without SINGLE_STEP_EN, PCUPD SHALL go directly to FETCH for free-running execution.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset; start; icode=6, new_pc=2 -> stages 1,2,3,4,5,6 each one cycle; wb_en high in stage 5; pc=2, instr_cnt=1.
- icode=5, mem_ack after 3 cycles -> mem_req high for exactly 3 cycles, then WRITEBACK; instr_cnt increments.
- icode=A, no mem_ack, MEM_TIMEOUT=4 -> mem_req high 4 cycles, then stat=3, halted=1, pc unchanged.
- FETCH with icode=0 -> stat=2, halted=1; a later start pulse keeps stage=7.
- FETCH with imem_err=1 and instr_valid=0 together -> stat=3 (ADR wins).
- rst_n low during a pending mem_req -> mem_req=0 and stage=0 immediately; pc=RESET_PC; instr_cnt=0. Also: SINGLE_STEP_EN build returns to stage=0 after each instruction.

Source files
------------

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer.
// It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
// and PCUPD. It owns the PC register, the retired-instruction counter and the
// halt status.
// Optional build macro SINGLE_STEP_EN: PCUPD returns to IDLE, so each start
// pulse executes exactly one instruction. Without it, PCUPD goes straight back
// to FETCH and execution runs freely.
module seq_ctrl #(
  parameter int unsigned          ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter int unsigned          MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_err,
  input  logic              dmem_err,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stage,
  output logic              mem_req,
  output logic              wb_en,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [31:0]       instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // The last wait cycle is the one whose counter value equals MEM_TIMEOUT-1.
  // MEM_TIMEOUT never exceeds 255, so 8 bits hold every count.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          stat_q, stat_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [7:0]          wait_q, wait_d;
  logic [3:0]          icode_q, icode_d;
  logic                is_mem_op;

  // Instructions that access data memory: loads, stores, calls, returns,
  // pushes and pops.
  assign is_mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  // State register. Reset is asynchronous, so an instruction caught
  // mid-flight is dropped without retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
      wait_q  <= '0;
      icode_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the old
      // values, which keeps the order of these statements irrelevant.
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      icode_q <= icode_d;
    end
  end

  // Next-state logic for the sequencer, the PC, the counters and the status.
  always_comb begin
    // NOTE: each signal defaults to its held value first, so every path
    // through the case assigns it and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    icode_d = icode_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        icode_d = icode;
        if (imem_err) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        wait_d  = '0;              // fresh wait budget on MEMORY entry
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_mem_op) begin
          state_d = S_WRITEBACK;   // no request, so mem_ack is ignored
        end else if (mem_ack) begin
          if (dmem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d  = new_pc;
        cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
`ifdef SINGLE_STEP_EN
        state_d = S_IDLE;
`else
        state_d = S_FETCH;
`endif
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // The strobes are decoded from the current state, so reset clears them
  // immediately. stat_q stays AOK until the cycle the block enters HALT.
  assign stage     = state_q;
  assign mem_req   = (state_q == S_MEMORY) && is_mem_op;
  assign wb_en     = (state_q == S_WRITEBACK);
  assign halted    = (state_q == S_HALT);
  assign stat      = stat_q;
  assign pc        = pc_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: self-checking bench for seq_ctrl.
// A transaction-level model predicts the expected cycle trace of each
// instruction, which the bench then compares cycle by cycle.
module tb_seq_ctrl;

  localparam int          AW  = 64;
  localparam logic [63:0] RPC = 64'h0000_0000_0000_1000;
  localparam int          TO  = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    icode;
  logic          instr_valid;
  logic          imem_err;
  logic          dmem_err;
  logic          mem_ack;
  logic [AW-1:0] new_pc;
  logic [AW-1:0] pc;
  logic [2:0]    stage;
  logic          mem_req;
  logic          wb_en;
  logic [2:0]    stat;
  logic          halted;
  logic [31:0]   instr_cnt;

  seq_ctrl #(.ADDR_W(AW), .RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_err(imem_err), .dmem_err(dmem_err),
    .mem_ack(mem_ack), .new_pc(new_pc), .pc(pc), .stage(stage),
    .mem_req(mem_req), .wb_en(wb_en), .stat(stat), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] stage;
    bit         mreq;
    bit         wb;
    bit         ack;
    bit         err;
  } cyc_t;

  typedef struct {
    logic [3:0] ic;
    bit         ierr;
    bit         iv;
    logic [2:0] exp_stat;
  } fetch_vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;
  logic [31:0] exp_cnt;
  bit          last_halt;
`ifdef SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; icode = '0; instr_valid = 1'b0;
    imem_err = 1'b0; dmem_err = 1'b0; mem_ack = 1'b0; new_pc = '0;
    step();
    step();
    rst_n   = 1'b1;
    exp_pc  = RPC;
    exp_cnt = '0;
  endtask

  task automatic go_fetch(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start"}, 64'(stage), 64'd1);
  endtask

  // Drives one instruction from FETCH to its end. ack_at is the MEMORY cycle
  // (1-based) that raises mem_ack; 0 or a value past TO means no ack.
  task automatic run_instr(input logic [3:0] ic, input bit ierr, input bit iv,
                           input int ack_at, input bit derr,
                           input logic [63:0] npc, input string tag);
    cyc_t       tr[$];
    logic [2:0] halt_code;
    bit         is_mem;
    int         n;
    halt_code = 3'd0;
    if (ierr)           halt_code = 3'd3;
    else if (!iv)       halt_code = 3'd4;
    else if (ic == 4'h0) halt_code = 3'd2;
    else begin
      is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      // A stray ack outside a pending request must be ignored.
      tr.push_back('{3'd2, 1'b0, 1'b0, 1'b1, 1'b1});
      tr.push_back('{3'd3, 1'b0, 1'b0, 1'b1, 1'b0});
      if (is_mem) begin
        n = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
        for (int k = 1; k <= n; k++)
          tr.push_back('{3'd4, 1'b1, 1'b0, k == ack_at, (k == ack_at) && derr});
        if (ack_at < 1 || ack_at > TO || derr) halt_code = 3'd3;
      end else begin
        tr.push_back('{3'd4, 1'b0, 1'b0, 1'b1, derr});
      end
      if (halt_code == 3'd0) begin
        tr.push_back('{3'd5, 1'b0, 1'b1, 1'b1, 1'b0});
        tr.push_back('{3'd6, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end

    icode = ic; imem_err = ierr; instr_valid = iv; new_pc = npc;
    step();
    // icode is sampled only in FETCH, so scramble it afterwards.
    icode = 4'($urandom); imem_err = 1'b0; instr_valid = 1'b0;
    foreach (tr[i]) begin
      check($sformatf("%s_cyc%0d", tag, i),
            {55'd0, stage, mem_req, wb_en, halted, stat},
            {55'd0, tr[i].stage, tr[i].mreq, tr[i].wb, 1'b0, 3'd1});
      mem_ack = tr[i].ack; dmem_err = tr[i].err;
      step();
      mem_ack = 1'b0; dmem_err = 1'b0;
    end

    last_halt = (halt_code != 3'd0);
    if (last_halt) begin
      check({tag, "_halt"}, {57'd0, stage, halted, stat}, {57'd0, 3'd7, 1'b1, halt_code});
    end else begin
      exp_pc  = npc;
      exp_cnt = (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
      check({tag, "_next"}, 64'(stage), SS ? 64'd0 : 64'd1);
    end
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_cnt"}, 64'(instr_cnt), 64'(exp_cnt));
    if (!last_halt && SS) go_fetch(tag);
  endtask

  fetch_vec_t fv[6];

  initial begin
    fv[0] = '{4'h0, 1'b1, 1'b0, 3'd3};  // ADR beats INS and HLT
    fv[1] = '{4'h5, 1'b1, 1'b1, 3'd3};
    fv[2] = '{4'h6, 1'b0, 1'b0, 3'd4};
    fv[3] = '{4'h0, 1'b0, 1'b0, 3'd4};  // INS beats HLT
    fv[4] = '{4'h0, 1'b0, 1'b1, 3'd2};
    fv[5] = '{4'h7, 1'b0, 1'b1, 3'd1};

    // Reset state.
    do_reset();
    check("rst_outs", {55'd0, stage, mem_req, wb_en, halted, stat}, {55'd0, 3'd0, 3'b000, 3'd1});
    check("rst_pc", pc, RPC);
    check("rst_cnt", 64'(instr_cnt), 64'd0);
    step();
    check("idle_hold", 64'(stage), 64'd0);

    // Plain ALU op, then a load acked on its third wait cycle.
    go_fetch("alu");
    run_instr(4'h6, 1'b0, 1'b1, 0, 1'b0, 64'd2, "alu");
    run_instr(4'h5, 1'b0, 1'b1, 3, 1'b0, 64'd7, "ld3");
    // Ack on the final allowed cycle is still in time.
    run_instr(4'h9, 1'b0, 1'b1, TO, 1'b0, 64'd9, "ackl");
    // Timeout without ack.
    run_instr(4'hA, 1'b0, 1'b1, 0, 1'b0, 64'd99, "tmo");

    // Data error on ack.
    do_reset();
    go_fetch("derr");
    run_instr(4'h8, 1'b0, 1'b1, 2, 1'b1, 64'd5, "derr");

    // HLT is absorbing, including against a later start pulse.
    do_reset();
    go_fetch("hlt");
    run_instr(4'h0, 1'b0, 1'b1, 0, 1'b0, 64'd3, "hlt");
    start = 1'b1; step(); start = 1'b0; step();
    check("hlt_absorb", {58'd0, stage, stat}, {58'd0, 3'd7, 3'd2});
    check("hlt_pc", pc, RPC);

    // FETCH priority table.
    foreach (fv[i]) begin
      do_reset();
      go_fetch($sformatf("tbl%0d", i));
      icode = fv[i].ic; imem_err = fv[i].ierr; instr_valid = fv[i].iv;
      step();
      check($sformatf("tbl%0d", i), {57'd0, stage, halted, stat},
            {57'd0, (fv[i].exp_stat == 3'd1) ? 3'd2 : 3'd7,
             fv[i].exp_stat != 3'd1, fv[i].exp_stat});
    end

    // Reset during a pending request.
    do_reset();
    go_fetch("rmr");
    run_instr(4'h2, 1'b0, 1'b1, 0, 1'b0, 64'h55, "rmr0");
    icode = 4'h5; instr_valid = 1'b1;
    step(); step(); step();
    check("rmr_req", {62'd0, stage == 3'd4, mem_req}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rmr_outs", {59'd0, stage, mem_req, wb_en}, 64'd0);
    check("rmr_pc", pc, RPC);
    check("rmr_cnt", 64'(instr_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    exp_pc = RPC; exp_cnt = '0;

    // Randomized instruction stream against the model.
    go_fetch("rnd");
    for (int t = 0; t < 200; t++) begin
      run_instr(4'($urandom), ($urandom % 16) == 0, ($urandom % 16) != 0,
                int'($urandom_range(0, TO + 1)), ($urandom % 8) == 0,
                {$urandom, $urandom}, $sformatf("rnd%0d", t));
      if (last_halt) begin
        do_reset();
        go_fetch("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
